// File: rtl/can_frame_pkg.sv
// Shared definitions for the CAN fault-frame sequencer slice: FSM state
// encoding, frame-segment lengths, bus-level constants and counter width.
package can_frame_pkg;

  localparam int unsigned FLAG_LEN         = 6;
  localparam int unsigned DELIM_LEN        = 8;
  localparam int unsigned INTERMISSION_LEN = 3;
  localparam int unsigned MAX_OVERLOAD     = 2;
  localparam int unsigned MAX_DOM_WAIT     = 7;
  localparam int unsigned INTEGRATE_LEN    = 11;

  localparam int unsigned CNT_W = 4;

  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

  typedef enum logic [2:0] {
    INTEGRATE    = 3'd0,
    BUS_IDLE     = 3'd1,
    RECEIVING    = 3'd2,
    INTERMISSION = 3'd3,
    ERR_FLAG     = 3'd4,
    OVL_FLAG     = 3'd5,
    WAIT_REC     = 3'd6,
    DELIM        = 3'd7
  } frame_state_e;

  // Terminal count for a segment of 'len' bits when the counter starts at 0.
  function automatic logic [CNT_W-1:0] last_bit(input int unsigned len);
    return CNT_W'(len - 1);
  endfunction

endpackage

// File: rtl/can_bit_counter.sv
// Saturating bit counter used to time CAN frame segments.
// Ports:
//   clk        - bit clock (sample point)
//   rst        - synchronous active-high reset
//   i_clr      - clear count to zero
//   i_load     - load i_load_val (wins over clear and increment)
//   i_load_val - value loaded by i_load
//   i_inc      - increment by one, holding at all-ones
//   i_term     - terminal count to compare against
//   o_tc       - high while count equals i_term
module can_bit_counter
  import can_frame_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == i_term);

endmodule

// File: rtl/can_fault_frame_sequencer.sv
// CAN error/overload frame sequencer. Advances one bit per samplePoint edge,
// drives canTX for error flags, overload flags, delimiters and intermission,
// and flags where a start of frame is legal.
// Ports:
//   samplePoint   - bit clock, one rising edge per CAN sample point
//   reset         - synchronous active-high reset
//   canRX         - sampled bus level (0 = dominant)
//   frameReady    - receiver has reached the last EOF bit
//   isError       - error detected this bit
//   overloadReq   - receiver asks for an overload delay
//   errorPassive  - (ERROR_PASSIVE_EN only) send passive (recessive) error flags
//   canTX         - registered bus drive (1 = recessive)
//   isStart       - one-bit pulse on a legal SOF
//   endOverload   - one-bit pulse on the last overload-delimiter bit
//   endError      - one-bit pulse on the last error-delimiter bit
//   busIdle       - high while in BUS_IDLE
//   stuckDominant - sticky: bus stayed dominant too long after our flag
//   frameState    - current state encoding
// Build option: define ERROR_PASSIVE_EN to add the errorPassive input.
module can_fault_frame_sequencer
  import can_frame_pkg::*;
(
  input  logic       samplePoint,
  input  logic       reset,
  input  logic       canRX,
  input  logic       frameReady,
  input  logic       isError,
  input  logic       overloadReq,
`ifdef ERROR_PASSIVE_EN
  input  logic       errorPassive,
`endif
  output logic       canTX,
  output logic       isStart,
  output logic       endOverload,
  output logic       endError,
  output logic       busIdle,
  output logic       stuckDominant,
  output logic [2:0] frameState
);

  frame_state_e     r_state;
  frame_state_e     w_next;
  logic             r_tx;
  logic             r_start;
  logic             r_end_ovl;
  logic             r_end_err;
  logic             r_idle;
  logic             r_stuck;
  logic             r_is_ovl;
  logic [CNT_W-1:0] r_ovl_cnt;

  logic             w_tx;
  logic             w_start;
  logic             w_end_ovl;
  logic             w_end_err;
  logic             w_stuck_set;
  logic             w_ovl_inc;
  logic             w_ovl_clr;
  logic             w_ovl_allowed;
  logic             w_flag_level;

  logic             w_len_clr;
  logic             w_len_load;
  logic             w_len_inc;
  logic [CNT_W-1:0] w_len_term;
  logic             w_len_tc;
  logic             w_dom_clr;
  logic             w_dom_inc;
  logic             w_dom_tc;

`ifdef ERROR_PASSIVE_EN
  logic             r_prev_rx;

  always_ff @(posedge samplePoint) begin
    if (reset) begin
      r_prev_rx <= RECESSIVE;
    end else begin
      r_prev_rx <= canRX;
    end
  end

  assign w_flag_level = errorPassive ? RECESSIVE : DOMINANT;
`else
  assign w_flag_level = DOMINANT;
`endif

  assign w_ovl_allowed = (r_ovl_cnt < CNT_W'(MAX_OVERLOAD));

  // Segment length counter: integration, flags, delimiter, intermission.
  can_bit_counter u_len_cnt (
    .clk        (samplePoint),
    .rst        (reset),
    .i_clr      (w_len_clr),
    .i_load     (w_len_load),
    .i_load_val (CNT_W'(1)),
    .i_inc      (w_len_inc),
    .i_term     (w_len_term),
    .o_tc       (w_len_tc)
  );

  // Dominant bits seen while waiting for the bus to release after a flag.
  can_bit_counter u_dom_cnt (
    .clk        (samplePoint),
    .rst        (reset),
    .i_clr      (w_dom_clr),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (w_dom_inc),
    .i_term     (CNT_W'(MAX_DOM_WAIT)),
    .o_tc       (w_dom_tc)
  );

  always_comb begin
    w_next      = r_state;
    w_tx        = RECESSIVE;
    w_start     = 1'b0;
    w_end_ovl   = 1'b0;
    w_end_err   = 1'b0;
    w_stuck_set = 1'b0;
    w_ovl_inc   = 1'b0;
    w_ovl_clr   = 1'b0;
    w_len_clr   = 1'b0;
    w_len_load  = 1'b0;
    w_len_inc   = 1'b0;
    w_dom_clr   = 1'b0;
    w_dom_inc   = 1'b0;

    case (r_state)
      INTEGRATE:    w_len_term = last_bit(INTEGRATE_LEN);
      INTERMISSION: w_len_term = last_bit(INTERMISSION_LEN);
      DELIM:        w_len_term = last_bit(DELIM_LEN);
      default:      w_len_term = last_bit(FLAG_LEN);
    endcase

    if ((r_state != INTEGRATE) && isError) begin
      // Any error (even mid-flag) restarts a full error flag.
      w_next    = ERR_FLAG;
      w_len_clr = 1'b1;
      w_tx      = w_flag_level;
    end else begin
      case (r_state)
        INTEGRATE: begin
          if (canRX == DOMINANT) begin
            w_len_clr = 1'b1;
          end else if (w_len_tc) begin
            w_next    = BUS_IDLE;
            w_len_clr = 1'b1;
          end else begin
            w_len_inc = 1'b1;
          end
        end

        BUS_IDLE: begin
          if (canRX == DOMINANT) begin
            w_next    = RECEIVING;
            w_start   = 1'b1;
            w_ovl_clr = 1'b1;
          end
        end

        RECEIVING: begin
          if (frameReady) begin
            w_next    = INTERMISSION;
            w_len_clr = 1'b1;
          end
        end

        INTERMISSION: begin
          // Dominant on bits 1-2 is an overload condition even once the
          // request budget is spent; dominant on bit 3 is a legal SOF.
          if (((canRX == DOMINANT) && !w_len_tc) || (overloadReq && w_ovl_allowed)) begin
            w_next    = OVL_FLAG;
            w_len_clr = 1'b1;
            w_ovl_inc = 1'b1;
            w_tx      = DOMINANT;
          end else if (canRX == DOMINANT) begin
            w_next    = RECEIVING;
            w_start   = 1'b1;
            w_ovl_clr = 1'b1;
          end else if (w_len_tc) begin
            w_next    = BUS_IDLE;
          end else begin
            w_len_inc = 1'b1;
          end
        end

        ERR_FLAG: begin
`ifdef ERROR_PASSIVE_EN
          // A passive flag only ends after FLAG_LEN equal bus bits; a level
          // change starts a new run of length one.
          if (errorPassive && (canRX != r_prev_rx)) begin
            w_len_load = 1'b1;
            w_tx       = w_flag_level;
          end else
`endif
          if (w_len_tc) begin
            w_next    = WAIT_REC;
            w_dom_clr = 1'b1;
          end else begin
            w_len_inc = 1'b1;
            w_tx      = w_flag_level;
          end
        end

        OVL_FLAG: begin
          if (w_len_tc) begin
            w_next    = WAIT_REC;
            w_dom_clr = 1'b1;
          end else begin
            w_len_inc = 1'b1;
            w_tx      = DOMINANT;
          end
        end

        WAIT_REC: begin
          if (canRX == RECESSIVE) begin
            // The releasing recessive bit is delimiter bit 1.
            w_next     = DELIM;
            w_len_load = 1'b1;
          end else if (w_dom_tc) begin
            w_stuck_set = 1'b1;
            w_dom_clr   = 1'b1;
          end else begin
            w_dom_inc = 1'b1;
          end
        end

        DELIM: begin
          if (canRX == DOMINANT) begin
            w_next    = ERR_FLAG;
            w_len_clr = 1'b1;
            w_tx      = w_flag_level;
          end else if (w_len_tc) begin
            w_next    = INTERMISSION;
            w_len_clr = 1'b1;
            w_end_ovl = r_is_ovl;
            w_end_err = !r_is_ovl;
          end else begin
            w_len_inc = 1'b1;
          end
        end

        default: w_next = INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge samplePoint) begin
    if (reset) begin
      r_state   <= INTEGRATE;
      r_tx      <= RECESSIVE;
      r_start   <= 1'b0;
      r_end_ovl <= 1'b0;
      r_end_err <= 1'b0;
      r_idle    <= 1'b0;
      r_stuck   <= 1'b0;
      r_is_ovl  <= 1'b0;
      r_ovl_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_tx      <= w_tx;
      r_start   <= w_start;
      r_end_ovl <= w_end_ovl;
      r_end_err <= w_end_err;
      r_idle    <= (w_next == BUS_IDLE);
      r_stuck   <= r_stuck | w_stuck_set;
      if (w_next == ERR_FLAG) begin
        r_is_ovl <= 1'b0;
      end else if (w_next == OVL_FLAG) begin
        r_is_ovl <= 1'b1;
      end
      if (w_ovl_clr) begin
        r_ovl_cnt <= '0;
      end else if (w_ovl_inc && (r_ovl_cnt != '1)) begin
        r_ovl_cnt <= r_ovl_cnt + 1'b1;
      end
    end
  end

  assign canTX         = r_tx;
  assign isStart       = r_start;
  assign endOverload   = r_end_ovl;
  assign endError      = r_end_err;
  assign busIdle       = r_idle;
  assign stuckDominant = r_stuck;
  assign frameState    = r_state;

endmodule

// File: tb/tb_can_fault_frame_sequencer.sv
module tb_can_fault_frame_sequencer;

  localparam logic [2:0] S_INT  = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_RX   = 3'd2;
  localparam logic [2:0] S_IM   = 3'd3;
  localparam logic [2:0] S_EF   = 3'd4;
  localparam logic [2:0] S_OF   = 3'd5;
  localparam logic [2:0] S_WR   = 3'd6;
  localparam logic [2:0] S_DL   = 3'd7;

  typedef struct packed {
    logic       tx;
    logic       start;
    logic       eovl;
    logic       eerr;
    logic       idle;
    logic       stuck;
    logic [2:0] st;
  } exp_t;

  logic       samplePoint = 1'b0;
  logic       reset = 1'b1;
  logic       canRX = 1'b1;
  logic       frameReady = 1'b0;
  logic       isError = 1'b0;
  logic       overloadReq = 1'b0;
  logic       errorPassive = 1'b0;
  logic       canTX;
  logic       isStart;
  logic       endOverload;
  logic       endError;
  logic       busIdle;
  logic       stuckDominant;
  logic [2:0] frameState;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_stuck = 1'b0;
  exp_t sb[$];
  string tq[$];

  can_fault_frame_sequencer dut (
    .samplePoint   (samplePoint),
    .reset         (reset),
    .canRX         (canRX),
    .frameReady    (frameReady),
    .isError       (isError),
    .overloadReq   (overloadReq),
`ifdef ERROR_PASSIVE_EN
    .errorPassive  (errorPassive),
`endif
    .canTX         (canTX),
    .isStart       (isStart),
    .endOverload   (endOverload),
    .endError      (endError),
    .busIdle       (busIdle),
    .stuckDominant (stuckDominant),
    .frameState    (frameState)
  );

  always #5 samplePoint = ~samplePoint;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t ex(input logic tx, input logic [2:0] st,
                              input logic start = 1'b0, input logic eovl = 1'b0,
                              input logic eerr = 1'b0);
    exp_t e;
    e.tx    = tx;
    e.start = start;
    e.eovl  = eovl;
    e.eerr  = eerr;
    e.idle  = (st == S_IDLE);
    e.stuck = exp_stuck;
    e.st    = st;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one bit, let one sample point pass, then compare against the
  // oldest expectation in the scoreboard.
  task automatic step(input string tag, input logic rx, input logic err,
                      input logic ovl, input logic fr, input exp_t e);
    exp_t  x;
    string t;
    sb.push_back(e);
    tq.push_back(tag);
    canRX       = rx;
    isError     = err;
    overloadReq = ovl;
    frameReady  = fr;
    @(posedge samplePoint);
    #1;
    x = sb.pop_front();
    t = tq.pop_front();
    chk({t, ".canTX"},         {2'b0, canTX},         {2'b0, x.tx});
    chk({t, ".isStart"},       {2'b0, isStart},       {2'b0, x.start});
    chk({t, ".endOverload"},   {2'b0, endOverload},   {2'b0, x.eovl});
    chk({t, ".endError"},      {2'b0, endError},      {2'b0, x.eerr});
    chk({t, ".busIdle"},       {2'b0, busIdle},       {2'b0, x.idle});
    chk({t, ".stuckDominant"}, {2'b0, stuckDominant}, {2'b0, x.stuck});
    chk({t, ".frameState"},    frameState,            x.st);
  endtask

  // Remaining 5 flag bits, flag end, 8-bit delimiter ending in a pulse.
  task automatic flag_delim(input string tag, input logic [2:0] fst, input logic is_ovl);
    for (int i = 0; i < 5; i++) step({tag, ".flag"}, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, fst));
    step({tag, ".flag_end"}, 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, S_WR));
    step({tag, ".wr_rec"},   1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_DL));
    for (int i = 0; i < 6; i++) step({tag, ".delim"}, 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_DL));
    step({tag, ".delim_end"}, 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_IM, 1'b0, is_ovl, !is_ovl));
  endtask

  task automatic integrate_to_idle();
    for (int i = 0; i < 10; i++) step("int", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_INT));
    step("int_done", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_IDLE));
  endtask

  initial begin
    // Reset values
    reset = 1'b1;
    step("rst0", 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, S_INT));
    step("rst1", 1'b1, 1'b1, 1'b1, 1'b1, ex(1'b1, S_INT));
    reset = 1'b0;

    // Integration: a dominant bit restarts the 11-bit count
    for (int i = 0; i < 5; i++) step("int_a", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_INT));
    step("int_dom", 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, S_INT));
    integrate_to_idle();
    step("idle_hold", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_IDLE));
    step("sof", 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, S_RX, 1'b1));
    step("rx_bit", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_RX));

    // Error frame: 6 dominant bits, 8-bit delimiter, intermission, idle
    step("err_in", 1'b1, 1'b1, 1'b0, 1'b0, ex(1'b0, S_EF));
    flag_delim("err", S_EF, 1'b0);
    step("im1", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_IM));
    step("im2", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_IM));
    step("im3", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_IDLE));

    // Overload frames: dominant on intermission bit 2, then one request,
    // then a third request that must be ignored
    step("sof2", 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, S_RX, 1'b1));
    step("frame_rdy", 1'b1, 1'b0, 1'b0, 1'b1, ex(1'b1, S_IM));
    step("ov_im1", 1'b1, 1'b0, 1'b0, 1'b1, ex(1'b1, S_IM));
    step("ov_im2_dom", 1'b0, 1'b0, 1'b0, 1'b1, ex(1'b0, S_OF));
    flag_delim("ovl1", S_OF, 1'b1);
    step("ovl_req2", 1'b1, 1'b0, 1'b1, 1'b0, ex(1'b0, S_OF));
    flag_delim("ovl2", S_OF, 1'b1);
    step("ovl_req3", 1'b1, 1'b0, 1'b1, 1'b0, ex(1'b1, S_IM));
    step("ovl_req3_b2", 1'b1, 1'b0, 1'b1, 1'b0, ex(1'b1, S_IM));
    step("ovl_req3_b3", 1'b1, 1'b0, 1'b1, 1'b0, ex(1'b1, S_IDLE));

    // Dominant intermission bit 3 is a start of frame
    step("sof3", 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, S_RX, 1'b1));
    step("frame_rdy3", 1'b1, 1'b0, 1'b0, 1'b1, ex(1'b1, S_IM));
    step("b3_im1", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_IM));
    step("b3_im2", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_IM));
    step("b3_im3_dom", 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, S_RX, 1'b1));
    step("b3_rx", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_RX));

    // Stuck dominant after own flag, then form error in delimiter bit 4
    step("err_in2", 1'b1, 1'b1, 1'b0, 1'b0, ex(1'b0, S_EF));
    for (int i = 0; i < 5; i++) step("sd_flag", 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, S_EF));
    step("sd_flag_end", 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, S_WR));
    for (int i = 1; i <= 10; i++) begin
      if (i == 8) exp_stuck = 1'b1;
      step("sd_wait", 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, S_WR));
    end
    step("sd_rec", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_DL));
    step("sd_dl2", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_DL));
    step("sd_dl3", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_DL));
    step("form_err", 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, S_EF));
    step("fe_flag1", 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, S_EF));
    step("fe_flag2", 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, S_EF));

    // isError mid-flag restarts the flag at bit 0
    step("restart", 1'b0, 1'b1, 1'b0, 1'b0, ex(1'b0, S_EF));
    for (int i = 0; i < 5; i++) step("restart_flag", 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b0, S_EF));

    // Reset mid-flag
    reset = 1'b1;
    exp_stuck = 1'b0;
    step("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, S_INT));
    reset = 1'b0;

`ifdef ERROR_PASSIVE_EN
    // Passive flag: recessive drive, ends after 6 equal bus bits
    integrate_to_idle();
    step("p_sof", 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, S_RX, 1'b1));
    errorPassive = 1'b1;
    step("p_err", 1'b1, 1'b1, 1'b0, 1'b0, ex(1'b1, S_EF));
    step("p_tog0", 1'b0, 1'b0, 1'b0, 1'b0, ex(1'b1, S_EF));
    step("p_tog1", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_EF));
    for (int i = 0; i < 4; i++) step("p_eq", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_EF));
    step("p_end", 1'b1, 1'b0, 1'b0, 1'b0, ex(1'b1, S_WR));
    errorPassive = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
